immenc: RTL

IMMENC -- requirements
Module: immenc

---
 rtl/immenc_if.sv | 24 ++
 rtl/immenc.sv | 134 +++++++++++++
 2 files changed

// File: rtl/immenc_if.sv
// Request/response bundle for the immediate encoder.
// The master drives requests and the consumer ready; the slave returns the encoded result.
interface immenc_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_imm_sel;
  logic [31:0] i_imm;
  logic [24:0] i_base;
  logic        o_valid;
  logic        i_ready;
  logic [24:0] o_data;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  modport master (
    output i_valid, i_imm_sel, i_imm, i_base, i_ready,
    input  o_ready, o_valid, o_data, o_err, o_err_cnt
  );

  modport slave (
    input  i_valid, i_imm_sel, i_imm, i_base, i_ready,
    output o_ready, o_valid, o_data, o_err, o_err_cnt
  );
endinterface

// File: rtl/immenc.sv
// Two-entry FIFO: write visible on the read side one edge later.
// Latency 1 cycle; wr_rdy drops when full, no push then even if a pop happens.
// Backpressure: rd_rdy low holds the head entry stable.
module immenc_fifo #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   occ;
  logic         push;
  logic         pop;

  assign wr_rdy = (occ != 2'd2);
  assign rd_vld = (occ != 2'd0);
  assign rd_dat = mem[rptr];
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_vld & rd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_dat;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// RISC-V immediate encoder: scatters a 32-bit immediate into instruction bits [31:7].
// Latency 1 cycle through a 2-entry result FIFO.
// Backpressure: o_ready low while the FIFO is full; head held while i_ready is low.
module immenc (
  input  logic     i_clk,
  input  logic     i_reset,
  immenc_if.slave  io
);
  logic [24:0] d;
  logic        err;
  logic [25:0] head;
  logic        acc;
  logic [7:0]  err_cnt;

  always_comb begin
    d   = io.i_base;
    err = 1'b0;
    case (io.i_imm_sel)
      3'b000: begin
        d   = io.i_base;
        err = 1'b0;
      end
      3'b001: begin
        d[24:13] = io.i_imm[11:0];
        err      = (io.i_imm[31:11] != {21{io.i_imm[11]}});
      end
      3'b010: begin
        d[24:18] = io.i_imm[11:5];
        d[4:0]   = io.i_imm[4:0];
        err      = (io.i_imm[31:11] != {21{io.i_imm[11]}});
      end
      3'b011: begin
        d[24]    = io.i_imm[12];
        d[0]     = io.i_imm[11];
        d[23:18] = io.i_imm[10:5];
        d[4:1]   = io.i_imm[4:1];
        err      = (io.i_imm[31:12] != {20{io.i_imm[12]}}) | io.i_imm[0];
      end
      3'b100: begin
        d[24:5] = io.i_imm[31:12];
        err     = |io.i_imm[11:0];
      end
      3'b101: begin
        d[24]    = io.i_imm[20];
        d[12:5]  = io.i_imm[19:12];
        d[13]    = io.i_imm[11];
        d[23:14] = io.i_imm[10:1];
        err      = (io.i_imm[31:20] != {12{io.i_imm[20]}}) | io.i_imm[0];
      end
      default: begin
        d   = io.i_base;
        err = 1'b1;
      end
    endcase
  end

  immenc_fifo #(.W(26)) u_fifo (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .wr_vld (io.i_valid),
    .wr_rdy (io.o_ready),
    .wr_dat ({d, err}),
    .rd_vld (io.o_valid),
    .rd_rdy (io.i_ready),
    .rd_dat (head)
  );

  assign io.o_data = head[25:1];
  assign io.o_err  = head[0];
  assign acc       = io.i_valid & io.o_ready;

  // Saturating: sticks at 255 rather than wrapping.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      err_cnt <= 8'd0;
    end else if (acc && err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign io.o_err_cnt = err_cnt;
endmodule
